imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch sequencer between the core's decode stage and the single-cycle instruction memory (`instruct_mem`). It owns the program counter and drives the memory read address. It compensates for the memory's one-cycle registered read latency and presents fetched words to decode through a valid/ready handshake. It also handles backpressure by replaying the in-flight address, and control-flow redirects by flushing stale fetches.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `MEM_DEPTH`, 64: instruction memory depth in 32-bit words; used only by the bounds check.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_addr`  out  32: byte address to the memory's `read_address`. Combinational from registered state and `redirect_valid`/`redirect_pc`/`inst_ready`.
- `mem_rdata`  in  32: the memory's `instruction_out`. Holds the word addressed by `mem_addr` in the previous cycle.
- `inst_valid`  out  1: the `inst`/`inst_pc` pair is valid.
- `inst_ready`  in  1: decode accepts the pair this cycle.
- `inst`  out  32: fetched instruction word.
- `inst_pc`  out  32: byte address of `inst`.
- `redirect_valid`  in  1: branch/jump target is valid this cycle.
- `redirect_pc`  in  32: target byte address. Bits [1:0] are ignored and treated as 00.
- `fetch_fault`  out  1: out-of-range fetch detected. Tied 0 unless the macro is defined.

## Operation
- Registers:
  - `fetch_pc`: next address to issue.
  - `inflight_valid`, `inflight_pc`: identify which address `mem_rdata` currently holds.
  - Output stage: `inst_valid`, `inst`, `inst_pc`.
  - `state`: RUN or FAULT.
- `advance = !inst_valid || inst_ready`. `stall = !advance`.
- Address mux, in priority order:
  - `redirect_valid`: `{redirect_pc[31:2],2'b00}`
  - `stall`: `inflight_pc` (replay keeps `mem_rdata` coherent)
  - otherwise: `fetch_pc`
- RUN, no redirect, advance:
  - Output stage loads `{inflight_valid, mem_rdata, inflight_pc}`.
  - `inflight_pc` ← `fetch_pc`; `inflight_valid` ← 1.
  - `fetch_pc` ← `fetch_pc + 4`, wrapping mod 2^32.
- RUN, no redirect, stall: all registers hold.
- Redirect, in any state, with priority over stall and fault:
  - `inst_valid` ← 0. Any presented word is discarded.
  - If `inst_ready` is also high, that handshake counts as completed.
  - `inflight_pc` ← aligned target; `inflight_valid` ← 1.
  - `fetch_pc` ← aligned target + 4.
  - `state` ← RUN; `fetch_fault` ← 0.
- Every handshake (`inst_valid && inst_ready`) delivers each sequential PC exactly once. There are no duplicates or gaps across stalls.

## Timing
- Reset values:
  - `inst_valid`, `inst`, `inst_pc`, `inflight_valid`, `fetch_fault` are all 0.
  - `inflight_pc` = `fetch_pc` = `RESET_PC`; `state` = RUN.
  - `mem_addr` = `RESET_PC`.
- After reset release:
  - Edge 1 marks `RESET_PC` in flight.
  - Edge 2 captures its word.
  - `inst_valid` is high from edge 2, with `inst_pc` = `RESET_PC`.
- Steady state with `inst_ready` = 1: one instruction per cycle.
- Redirect asserted in cycle N:
  - `inst_valid` is low in cycle N+1.
  - The target word is presented in cycle N+2.
  - Cost is one bubble.
- Reset asserted mid-operation clears all state immediately, with no completion of a pending handshake.
- `redirect_valid` together with `stall`: the redirect wins and the stalled word is dropped.

## Configuration
- `IFETCH_BOUNDS_CHECK_EN` defined:
  - If an advance would load an `inflight_pc` ≥ `MEM_DEPTH*4` into the output stage, the word is not presented.
  - `inst_valid` ← 0, `fetch_fault` ← 1, `inflight_valid` ← 0, `state` ← FAULT.
  - In FAULT: `mem_addr` = `fetch_pc` and nothing advances. Only a redirect or reset leaves FAULT.
- Macro undefined:
  - No FAULT state; `fetch_fault` is constant 0.
  - Addresses beyond the memory are fetched unchecked.

## Test plan
- Reset, then release with `inst_ready` = 1. Required response:
  - `inst_valid` rises at the 2nd edge.
  - Sequence is (0x0, 00500113), (0x4, 00A00193), (0x8, 00310233), (0xC, 00412023).
- `inst_ready` low for 3 cycles while (0x8, 00310233) is presented. Required response:
  - The pair holds constant and `mem_addr` = 0xC throughout.
  - After release, the next pair is (0xC, 00412023) with no skip or duplicate.
- Redirect to 0x14 while 0x8 is presented. Required response:
  - One cycle with `inst_valid` = 0.
  - Then (0x14, 0061A463), (0x18, 00120213).
- Redirect to 0x1E, misaligned, while stalled. Required response:
  - Stalled word is dropped.
  - Next pair is (0x1C, FE0006E3).
- Reset pulsed mid-stream at pc 0x10. Required response:
  - `inst_valid` is 0 immediately.
  - Restart from 0x0 with the 2-edge latency.
- With `IFETCH_BOUNDS_CHECK_EN`, redirect to 0xFC. Required response:
  - 0xFC is delivered, then `fetch_fault` = 1 and `inst_valid` = 0 instead of 0x100.
  - A redirect to 0x0 clears the fault and delivers (0x0, 00500113) two cycles later.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer between decode and a single-cycle registered
// instruction memory. Owns the program counter and drives the memory read
// address. It hides the one-cycle read latency and hands fetched words to
// decode over a valid/ready handshake. Backpressure replays the in-flight
// address so mem_rdata stays coherent. Redirects flush stale fetches and
// cost one bubble.
//
// Optional feature macro: IFETCH_BOUNDS_CHECK_EN
//   When defined, a fetch beyond MEM_DEPTH words is not presented. Instead
//   the block parks in a FAULT state with fetch_fault high until a redirect
//   or reset. When undefined, fetch_fault is tied 0 and out-of-range
//   addresses are fetched unchecked.
//
// Parameters:
//   RESET_PC   byte address fetched first after reset
//   MEM_DEPTH  instruction memory depth in 32-bit words (bounds check only)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   mem_addr        byte read address to the instruction memory
//   mem_rdata       memory word addressed by mem_addr in the previous cycle
//   inst_valid      inst/inst_pc pair is valid
//   inst_ready      decode accepts the pair this cycle
//   inst            fetched instruction word
//   inst_pc         byte address of inst
//   redirect_valid  branch/jump target valid this cycle
//   redirect_pc     target byte address (bits [1:0] ignored)
//   fetch_fault     out-of-range fetch detected
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        inflight_valid;
    logic        advance;
    logic        stall;
    logic [31:0] redirect_tgt;

`ifdef IFETCH_BOUNDS_CHECK_EN
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    // 33 bits so a 2^30-word memory still has a representable byte limit
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;

    logic [0:0] state;
    logic       out_of_range;

    assign out_of_range = inflight_valid && ({1'b0, inflight_pc} >= MEM_BYTES);
`else
    // MEM_DEPTH only matters to the bounds check
    logic unused_mem_depth;
    assign unused_mem_depth = ^MEM_DEPTH;
    assign fetch_fault      = 1'b0;
`endif

    assign advance      = !inst_valid || inst_ready;
    assign stall        = !advance;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    // Redirect beats everything. While stalled, re-issue the in-flight address
    // so the memory keeps returning the word that has not yet been captured.
    always_comb begin
        mem_addr = fetch_pc;
        if (redirect_valid) begin
            mem_addr = redirect_tgt;
        end
`ifdef IFETCH_BOUNDS_CHECK_EN
        else if (state == ST_FAULT) begin
            mem_addr = fetch_pc;
        end
`endif
        else if (stall) begin
            mem_addr = inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= RESET_PC;
            inflight_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
`ifdef IFETCH_BOUNDS_CHECK_EN
            state          <= ST_RUN;
            fetch_fault    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Drop whatever is presented; any simultaneous handshake has
            // already been consumed by decode this cycle.
            inst_valid     <= 1'b0;
            inflight_pc    <= redirect_tgt;
            inflight_valid <= 1'b1;
            fetch_pc       <= redirect_tgt + 32'd4;
`ifdef IFETCH_BOUNDS_CHECK_EN
            state          <= ST_RUN;
            fetch_fault    <= 1'b0;
`endif
        end
`ifdef IFETCH_BOUNDS_CHECK_EN
        else if (state == ST_FAULT) begin
            // parked until redirect or reset
        end
`endif
        else if (advance) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
            if (out_of_range) begin
                inst_valid     <= 1'b0;
                inflight_valid <= 1'b0;
                fetch_fault    <= 1'b1;
                state          <= ST_FAULT;
            end else
`endif
            begin
                inst_valid     <= inflight_valid;
                inst           <= mem_rdata;
                inst_pc        <= inflight_pc;
                inflight_pc    <= fetch_pc;
                inflight_valid <= 1'b1;
                fetch_pc       <= fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Bench for imem_fetch_ctrl. A registered instruction memory model feeds
// mem_rdata. Per-cycle expectations come from a vector table plus
// hand-written reset and bounds sequences. Every accepted handshake is also
// checked against a scoreboard queue that the driver fills.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[22];

    imem_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MEM_DEPTH(64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program image; words outside the 64-word memory read as 0.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] w;
        if (a >= 32'd256) begin
            w = 32'h0000_0000;
        end else begin
            case (a)
                32'h00:  w = 32'h0050_0113;
                32'h04:  w = 32'h00A0_0193;
                32'h08:  w = 32'h0031_0233;
                32'h0C:  w = 32'h0041_2023;
                32'h10:  w = 32'h0020_8093;
                32'h14:  w = 32'h0061_A463;
                32'h18:  w = 32'h0012_0213;
                32'h1C:  w = 32'hFE00_06E3;
                default: w = {16'hC0DE, a[15:0]};
            endcase
        end
        return w;
    endfunction

    always @(posedge clk) mem_rdata <= exp_word(mem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Handshake monitor: each accepted pair must be the next one expected.
    always @(negedge clk) begin
        if (!reset && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            logic [31:0] pc;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_handshake actual_pc=%h required=none", inst_pc);
            end else begin
                pc = sb_q.pop_front();
                check32("sb_pc", inst_pc, pc);
                check32("sb_inst", inst, exp_word(pc));
            end
        end
    end

    // One cycle: drive after the edge, check before the next one.
    task automatic cyc(input logic ready, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                       input logic efault);
        @(posedge clk);
        #1;
        inst_ready     = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (ready && ev) sb_q.push_back(epc);
        @(negedge clk);
        check32("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
        if (ev) begin
            check32("inst_pc", inst_pc, epc);
            check32("inst", inst, exp_word(epc));
        end
        check32("mem_addr", mem_addr, eaddr);
        check32("fetch_fault", {31'b0, fetch_fault}, {31'b0, efault});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ready rv  rpc       ev   pc        addr
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h04};
        vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 32'h08};
        vecs[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h0C};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C};
        vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 32'h10};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h14};
        vecs[8]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h10, 32'h00};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h04};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 32'h08};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h0C};
        vecs[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 32'h14};
        vecs[13] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h18};
        vecs[14] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h14, 32'h1C};
        vecs[15] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h18, 32'h1C};
        vecs[16] = '{1'b0, 1'b1, 32'h1E, 1'b1, 32'h18, 32'h1C};
        vecs[17] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h20};
        vecs[18] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h1C, 32'h24};
        vecs[19] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 32'h10};
        vecs[20] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h14};
        vecs[21] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 32'h14};

        reset          = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check32("rst_inst", inst, 32'd0);
        check32("rst_inst_pc", inst_pc, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        reset = 1'b0;
        #1;
        check32("rel_inst_valid", {31'b0, inst_valid}, 32'd0);
        check32("rel_mem_addr", mem_addr, 32'd0);

        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].ready, vecs[i].rv, vecs[i].rpc, vecs[i].exp_valid,
                vecs[i].exp_pc, vecs[i].exp_addr, 1'b0);
        end

        // Reset mid-stream while 0x10 is presented and stalled.
        #2;
        reset = 1'b1;
        #1;
        check32("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check32("midrst_inst_pc", inst_pc, 32'd0);
        check32("midrst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        inst_ready = 1'b1;
        #1;
        check32("restart_inst_valid", {31'b0, inst_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 32'h04, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 32'h08, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 32'h0C, 1'b0);

`ifdef IFETCH_BOUNDS_CHECK_EN
        cyc(1'b1, 1'b1, 32'hFC, 1'b1, 32'h08, 32'hFC,  1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h100, 1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b1, 32'hFC, 32'h104, 1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h104, 1'b1);
        cyc(1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h104, 1'b1);
        cyc(1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00,  1'b1);
        cyc(1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h04,  1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 32'h08,  1'b0);
`else
        cyc(1'b1, 1'b1, 32'hFC, 1'b1, 32'h08,  32'hFC,  1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h100, 1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b1, 32'hFC,  32'h104, 1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b1, 32'h100, 32'h108, 1'b0);
        cyc(1'b1, 1'b0, 32'h00, 1'b1, 32'h104, 32'h10C, 1'b0);
`endif

        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        @(negedge clk);
        check32("sb_leftover", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
